// File: rtl/kiscv_pkg.sv
// kiscv_pkg: shared types and constants for the alu_issue decode/issue slice.
//   - RV32I opcode constants used by the issue decoder
//   - 4-bit ALU op codes ({m3, funct3} encoding, ALU_BAD = error code)
//   - issue_kind_t: how execute should treat an issued op
//   - issue_bundle_t: one issued op as carried through the skid buffer
//   - skid_state_t: occupancy of the 2-entry skid buffer
package kiscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_BAD  = 4'b1111;

    typedef enum logic [1:0] {
        KIND_ALU     = 2'd0,
        KIND_BRANCH  = 2'd1,
        KIND_ILLEGAL = 2'd2,
        KIND_RSVD    = 2'd3
    } issue_kind_t;

    typedef struct packed {
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        issue_kind_t kind;
        logic [31:0] pc;
    } issue_bundle_t;

    localparam int BUNDLE_W = $bits(issue_bundle_t);

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and data signals around the alu_issue stage.
//   in_*  : register-read bundle entering the stage (valid/ready)
//   out_* : issued ALU op leaving towards execute (valid/ready)
// Modports:
//   master : the issue stage itself (accepts in_*, drives out_*)
//   slave  : the surrounding pipeline (drives in_*, accepts out_*)
interface alu_issue_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_m;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [1:0]      out_kind;
    logic [PC_W-1:0] out_pc;

    modport master (
        input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_m, out_a, out_b, out_imm,
               out_rd, out_kind, out_pc
    );

    modport slave (
        output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_m, out_a, out_b, out_imm,
               out_rd, out_kind, out_pc
    );
endinterface

// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry valid/ready register with registered in_ready.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake; in_ready = skid entry empty
//   in_data  [W]        : upstream payload
//   out_valid/out_ready : downstream handshake, 1-cycle latency
//   out_data [W]        : downstream payload, held while stalled
module skid_buffer
    import kiscv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    skid_state_t  state;
    logic         vld_p1;
    logic [W-1:0] data_p1;
    logic [W-1:0] skid_p1;

    assign in_ready  = (state == SKID_EMPTY);
    assign out_valid = vld_p1;
    assign out_data  = data_p1;

    // Stage boundary: output register plus one overflow (skid) entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SKID_EMPTY;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (in_valid) begin
                        // Output free or draining this cycle: reload directly,
                        // otherwise park the bundle in the skid entry.
                        if (!vld_p1 || out_ready) begin
                            data_p1 <= in_data;
                            vld_p1  <= 1'b1;
                        end else begin
                            skid_p1 <= in_data;
                            state   <= SKID_FULL;
                        end
                    end else if (out_ready) begin
                        vld_p1 <= 1'b0;
                    end
                end
                SKID_FULL: begin
                    // Input is blocked here; the output stays valid and the
                    // parked bundle moves up as soon as execute takes one.
                    if (out_ready) begin
                        data_p1 <= skid_p1;
                        state   <= SKID_EMPTY;
                    end
                end
                default: state <= SKID_EMPTY;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue stage driving the integer ALU (m/a/b).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_issue_if.master
//              in_valid/in_ready + in_instr/in_pc/in_rs1/in_rs2 from register read
//              out_valid/out_ready + out_m/out_a/out_b/out_imm/out_rd/out_kind/out_pc
//              to execute, one cycle after acceptance, through a 2-entry skid buffer
// Optional (macro KISCV_ALU_ISSUE_PERF_EN):
//   perf_issued  : output transfers, wraps mod 2^32
//   perf_illegal : output transfers with kind = illegal, wraps mod 2^32
module alu_issue
    import kiscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.master bus
`ifdef KISCV_ALU_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_illegal
`endif
);
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [PC_W-1:0] pc_in;
    logic            illegal;
    issue_bundle_t   dec;
    issue_bundle_t   q;
    logic [BUNDLE_W-1:0] dec_bits;
    logic [BUNDLE_W-1:0] q_bits;

    assign opc   = bus.in_instr[6:0];
    assign f3    = bus.in_instr[14:12];
    assign f7    = bus.in_instr[31:25];
    assign pc_in = bus.in_pc;
    assign imm_i = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_b = {{(XLEN-13){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                    bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
    assign imm_u = {bus.in_instr[31:12], 12'b0};
    // Shift-immediate ops feed only the shift amount to the ALU; imm[11:5]
    // is an opcode extension there, not part of the operand.
    assign shamt = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};

    always_comb begin
        dec      = '0;
        illegal  = 1'b0;
        dec.pc   = pc_in;
        dec.rd   = bus.in_instr[11:7];
        dec.kind = KIND_ALU;
        case (opc)
            OPC_OP: begin
                dec.a = bus.in_rs1;
                dec.b = bus.in_rs2;
                case ({f7, f3})
                    {7'b0000000, 3'b000}: dec.m = ALU_ADD;
                    {7'b0100000, 3'b000}: dec.m = ALU_SUB;
                    {7'b0000000, 3'b001}: dec.m = ALU_SLL;
                    {7'b0000000, 3'b010}: dec.m = ALU_SLT;
                    {7'b0000000, 3'b011}: dec.m = ALU_SLTU;
                    {7'b0000000, 3'b100}: dec.m = ALU_XOR;
                    {7'b0000000, 3'b101}: dec.m = ALU_SRL;
                    {7'b0100000, 3'b101}: dec.m = ALU_SRA;
                    {7'b0000000, 3'b110}: dec.m = ALU_OR;
                    {7'b0000000, 3'b111}: dec.m = ALU_AND;
                    default:              illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.a   = bus.in_rs1;
                dec.b   = imm_i;
                dec.imm = imm_i;
                dec.m   = {1'b0, f3};
                if (f3 == 3'b001) begin
                    dec.b   = shamt;
                    illegal = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec.b = shamt;
                    if (f7 == 7'b0100000)      dec.m = ALU_SRA;
                    else if (f7 != 7'b0000000) illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                dec.a    = bus.in_rs1;
                dec.b    = bus.in_rs2;
                dec.imm  = imm_b;
                dec.rd   = 5'd0;
                dec.kind = KIND_BRANCH;
                dec.m    = {1'b0, f3};
                // funct3 01x would select the undefined compare field.
                illegal  = (f3[2:1] == 2'b01);
            end
            OPC_LUI: begin
                dec.m   = ALU_ADD;
                dec.b   = imm_u;
                dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                dec.m   = ALU_ADD;
                dec.a   = pc_in;
                dec.b   = imm_u;
                dec.imm = imm_u;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec      = '0;
            dec.pc   = pc_in;
            dec.m    = ALU_BAD;
            dec.kind = KIND_ILLEGAL;
        end
    end

    assign dec_bits = dec;
    assign q        = issue_bundle_t'(q_bits);

    skid_buffer #(.W(BUNDLE_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (dec_bits),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (q_bits)
    );

    assign bus.out_m    = q.m;
    assign bus.out_a    = q.a;
    assign bus.out_b    = q.b;
    assign bus.out_imm  = q.imm;
    assign bus.out_rd   = q.rd;
    assign bus.out_kind = q.kind;
    assign bus.out_pc   = q.pc;

`ifdef KISCV_ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued  <= 32'd0;
            perf_illegal <= 32'd0;
        end else if (bus.out_valid && bus.out_ready) begin
            perf_issued <= perf_issued + 32'd1;
            if (q.kind == KIND_ILLEGAL) perf_illegal <= perf_illegal + 32'd1;
        end
    end
`endif
endmodule
